// File: rtl/imem_load_controller.sv
// Instruction-memory loader and pipeline sequencer: packs UART bytes into words, writes them
// from address 0 while holding the CPU in reset, then runs continuously or single-steps to halt.
module imem_load_controller #(
  parameter int unsigned       LEN       = 32,
  parameter int unsigned       ADDR_W    = 11,
  parameter logic [LEN-1:0]    HALT_WORD = 32'hFFFFFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_done,
  input  logic              i_mode,
  input  logic              i_run,
  input  logic              i_step,
  input  logic              i_halt,
  input  logic              i_clear,
  output logic              o_mem_wea,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [LEN-1:0]    o_mem_dina,
  output logic              o_cpu_rst,
  output logic              o_cpu_en,
  output logic              o_ready,
  output logic              o_done,
  output logic              o_overflow,
  output logic [ADDR_W:0]   o_word_count
);

  localparam int unsigned NB  = LEN / 8;
  localparam int unsigned BCW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [BCW-1:0]    LastByte = BCW'(NB - 1);
  localparam logic [BCW-1:0]    ByteOne  = BCW'(1);
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrTop  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   CountOne = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StReady,
    StRun,
    StStep,
    StDone
  } state_e;

  state_e            state;
  logic [BCW-1:0]    byte_cnt;
  logic [LEN-1:0]    shift;
  logic [ADDR_W-1:0] wr_addr;

  logic [LEN+7:0]    shift_ext;
  logic [LEN-1:0]    word_next;
  logic              last_byte;
  logic              is_halt;
  logic              at_top;
  logic              end_of_load;
  logic [ADDR_W-1:0] addr_now;

  always_comb begin
    shift_ext   = {shift, i_rx_data};
    word_next   = shift_ext[LEN-1:0];
    last_byte   = (byte_cnt == LastByte);
    // Decided on the write-strobe cycle, using the word/address being written.
    is_halt     = (o_mem_dina == HALT_WORD);
    at_top      = (o_mem_addr == AddrTop);
    end_of_load = o_mem_wea && (is_halt || at_top);
    // Address for a word completed in the same cycle as the previous write strobe.
    addr_now    = o_mem_wea ? (wr_addr + AddrOne) : wr_addr;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= StIdle;
      byte_cnt     <= '0;
      shift        <= '0;
      wr_addr      <= '0;
      o_word_count <= '0;
      o_mem_wea    <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_dina   <= '0;
      o_cpu_rst    <= 1'b1;
      o_cpu_en     <= 1'b0;
      o_ready      <= 1'b0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      o_mem_wea <= 1'b0;
      unique case (state)
        StIdle, StLoad: begin
          if (o_mem_wea) begin
            o_word_count <= o_word_count + CountOne;
            if (!at_top) begin
              wr_addr <= wr_addr + AddrOne;
            end
            if (end_of_load) begin
              state      <= StReady;
              o_ready    <= 1'b1;
              o_overflow <= !is_halt;
            end
          end
          // Bytes racing the final write are dropped: the load is over.
          if (i_rx_done && !end_of_load) begin
            state <= StLoad;
            shift <= word_next;
            if (last_byte) begin
              byte_cnt   <= '0;
              o_mem_wea  <= 1'b1;
              o_mem_addr <= addr_now;
              o_mem_dina <= word_next;
            end else begin
              byte_cnt <= byte_cnt + ByteOne;
            end
          end
        end
        StReady: begin
          if (i_run) begin
            state     <= i_mode ? StStep : StRun;
            o_ready   <= 1'b0;
            o_cpu_rst <= 1'b0;
            o_cpu_en  <= !i_mode;
          end
        end
        StRun: begin
          if (i_halt) begin
            state    <= StDone;
            o_cpu_en <= 1'b0;
            o_done   <= 1'b1;
          end
        end
        StStep: begin
          if (i_halt) begin
            state    <= StDone;
            o_cpu_en <= 1'b0;
            o_done   <= 1'b1;
          end else begin
            o_cpu_en <= i_step;
          end
        end
        StDone: begin
          // Pipeline stays frozen (no reset, no enable) until cleared; memory is kept.
          if (i_clear) begin
            state        <= StIdle;
            o_done       <= 1'b0;
            o_cpu_rst    <= 1'b1;
            wr_addr      <= '0;
            o_word_count <= '0;
            o_overflow   <= 1'b0;
            shift        <= '0;
            byte_cnt     <= '0;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
